alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Command issue and result capture stage wrapped around the team's combinational 8-bit ALU. Buffers incoming {a, b, op} commands in a small FIFO and presents the head entry on the ALU operand ports. Registers the ALU's result, zero and carry, tagged with the op, into a single output slot with a valid/ready handshake. Gives the datapath back-pressure and one registered result per command.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- CW, $clog2(DEPTH)+1, width of `count` (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO and output slot
- in_valid  in  1  command offered
- in_ready  out  1  command accepted when in_valid & in_ready
- in_a  in  8  operand A
- in_b  in  8  operand B
- in_op  in  3  ALU opcode (000 ADD … 111 SRL)
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_op  out  3  to ALU op
- alu_result  in  8  from ALU result
- alu_zero  in  1  from ALU zero
- alu_carry  in  1  from ALU carry
- out_valid  out  1  result slot occupied
- out_ready  in  1  consumer takes result when out_valid & out_ready
- out_result  out  8  registered result
- out_zero  out  1  registered zero flag
- out_carry  out  1  registered carry flag
- out_op  out  3  opcode that produced the result
- count  out  CW  FIFO occupancy, 0..DEPTH

## Operation
- FIFO: circular buffer with log2(DEPTH)-bit read/write pointers that wrap DEPTH-1→0, plus a CW-bit count.
- Handshake signals:
  - push = in_valid & in_ready.
  - in_ready = (count != DEPTH). No push while full, even in a pop cycle.
- ALU operand drive: alu_a/alu_b/alu_op are driven combinationally from the head entry. When the FIFO is empty they drive 0/0/000.
- Capture: fire = (count != 0) & (!out_valid | out_ready).
  - On fire, out_result/zero/carry ← alu_result/zero/carry, out_op ← head op, out_valid ← 1, head popped.
- Drain without refill: out_valid clears on out_ready & out_valid & !fire.
- Push and pop in the same cycle: count is unchanged, both pointers advance.
- No arithmetic is performed in the block. Flags are taken verbatim from the ALU.
- flush (sync, highest priority):
  - Pointers and count go to 0, out_valid goes to 0.
  - A push in the same cycle is dropped. Output data registers hold their values.
- No state machine beyond FIFO and slot occupancy. The output slot is a 2-state flag: EMPTY / FULL.

## Timing
- Reset (rst_n low, async):
  - count=0, pointers=0, out_valid=0, out_result=0, out_zero=0, out_carry=0, out_op=0.
  - in_ready=1 and alu_a/alu_b/alu_op=0 (combinational from count).
- Reset mid-operation discards all queued commands and any pending result. No partial output.
- Latency: command pushed at edge N is captured at edge N+1 at the earliest (out_valid high after N+1), if the FIFO was empty and the slot free or draining.
- Throughput: 1 result/cycle with out_ready held high.
- out_* registers are stable while out_valid & !out_ready.
- in_ready depends only on count (registered), not on in_valid or out_ready. There is no combinational path from out_ready to in_ready.
- alu_* are combinational from the FIFO head. The ALU→capture path is one cycle.

## Configuration
- ALU_ISSUE_BYPASS_EN defined:
  - When count==0, alu_a/alu_b/alu_op are driven from in_a/in_b/in_op.
  - If push occurs and the slot is free or draining, the command is captured directly at the same edge and is not written to the FIFO.
  - Latency becomes 0 cycles of queueing: out_valid high after edge N.
  - flush still suppresses the capture.
- Undefined: no bypass. alu_* come only from the FIFO head, and latency is as stated in Timing.

## Test plan
- Reset then a single ADD a=0x80 b=0x80, out_ready=1 -> out_valid one cycle after accept (bypass: same edge), out_result=0x00, out_zero=1, out_carry=1, out_op=000.
- Back-pressure: out_ready=0, push 5 commands with DEPTH=4 -> 1 held in the slot, count reaches 4, in_ready=0, the 6th in_valid is not accepted. Then raise out_ready -> results emerge in push order, one per cycle.
- Streaming: SUB 0x05-0x06, SLL 0x81, SRL 0x01, out_ready=1 -> results 0xFF/c=1, 0x02/c=1, 0x00/z=1/c=0 on consecutive cycles.
- Wrap-around: push/pop 3×DEPTH commands with a varying a -> no loss or reorder, count never exceeds DEPTH.
- Full plus simultaneous pop: count=DEPTH, out_ready=1, in_valid=1 -> that cycle pushes nothing, count becomes DEPTH-1.
- flush with count=3 and out_valid=1 plus in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, pushed command discarded. Async rst_n pulse mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Command issue and result capture stage around an external combinational
//   8-bit ALU. Incoming {a, b, op} commands are queued in a circular FIFO.
//   The head entry drives the ALU operand ports. The ALU's result, zero and
//   carry outputs, tagged with the op, are registered into a single output
//   slot that uses a valid/ready handshake.
//
//   Optional feature macro: ALU_ISSUE_BYPASS_EN
//     When this macro is defined and the FIFO is empty, the ALU is driven
//     straight from in_a/in_b/in_op. An accepted command is captured on the
//     same edge, provided the slot is free or draining.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of FIFO and output slot
//   in_valid/in_ready     command handshake; in_a, in_b, in_op carry the command
//   alu_a/alu_b/alu_op    operands to the ALU (head entry, or 0 when empty)
//   alu_result/zero/carry ALU outputs sampled on capture
//   out_valid/out_ready   result handshake; out_result/zero/carry/op carry the result
//   count                 FIFO occupancy, 0..DEPTH
module alu_issue_stage #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_a,
    input  logic [7:0]    in_b,
    input  logic [2:0]    in_op,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [7:0]    alu_result,
    input  logic          alu_zero,
    input  logic          alu_carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_result,
    output logic          out_zero,
    output logic          out_carry,
    output logic [2:0]    out_op,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] a;
    } cmd_t;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    slot_t         slot_q;
    slot_t         slot_d;

    logic empty;
    logic full;
    logic push;
    logic slot_free;
    logic pop;
    logic byp;
    logic fire;
    logic wr_en;
    cmd_t head;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !full;
    assign push      = in_valid & in_ready;
    assign slot_free = (slot_q == SLOT_EMPTY) | out_ready;
    assign pop       = !empty & slot_free;
`ifdef ALU_ISSUE_BYPASS_EN
    // An empty FIFO with a free slot lets the incoming command skip the queue.
    assign byp       = empty & push & slot_free;
`else
    assign byp       = 1'b0;
`endif
    assign fire      = pop | byp;
    assign wr_en     = push & !byp;
    assign head      = mem[rd_ptr];
    assign count     = count_q;
    assign out_valid = (slot_q == SLOT_FULL);

    // ALU operands
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!empty) begin
            alu_a  = head.a;
            alu_b  = head.b;
            alu_op = head.op;
        end
`ifdef ALU_ISSUE_BYPASS_EN
        else begin
            alu_a  = in_a;
            alu_b  = in_b;
            alu_op = in_op;
        end
`endif
    end

    // Output slot occupancy
    always_comb begin
        slot_d = slot_q;
        if (flush)
            slot_d = SLOT_EMPTY;
        else if (fire)
            slot_d = SLOT_FULL;
        else if (out_ready)
            slot_d = SLOT_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            slot_q <= SLOT_EMPTY;
        else
            slot_q <= slot_d;
    end

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en && !flush)
            mem[wr_ptr] <= cmd_t'{op: in_op, b: in_b, a: in_a};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(wr_en) - CW'(pop);
        end
    end

    // Result capture. alu_op already reflects the head op, or the bypassed op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
            out_op     <= '0;
        end else if (fire && !flush) begin
            out_result <= alu_result;
            out_zero   <= alu_zero;
            out_carry  <= alu_carry;
            out_op     <= alu_op;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic [2:0]    in_op;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [2:0]    alu_op;
    logic [7:0]    alu_result;
    logic          alu_zero;
    logic          alu_carry;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_result;
    logic          out_zero;
    logic          out_carry;
    logic [2:0]    out_op;
    logic [CW-1:0] count;

    alu_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_op     (out_op),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: returns {carry, zero, result}
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        c = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
            default: r = {1'b0, a[7:1]};
        endcase
        return {c, (r == 8'h00), r};
    endfunction

    always_comb {alu_carry, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_op);

    // Reference model: queue of pending commands plus the result slot
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    cmd_t       q[$];
    logic       m_valid;
    logic [7:0] m_res;
    logic       m_z;
    logic       m_c;
    logic [2:0] m_op;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input bit zero_data);
        q.delete();
        m_valid = 1'b0;
        if (zero_data) begin
            m_res = '0;
            m_z   = 1'b0;
            m_c   = 1'b0;
            m_op  = '0;
        end
    endtask

    task automatic load_slot(input cmd_t c);
        logic [9:0] r;
        r       = alu_fn(c.a, c.b, c.op);
        m_res   = r[7:0];
        m_z     = r[8];
        m_c     = r[9];
        m_op    = c.op;
        m_valid = 1'b1;
    endtask

    task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic ordy, input logic fl);
        cmd_t c;
        bit   ready;
        bit   push;
        bit   sfree;
        @(negedge clk);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        flush     = fl;
        #1;
        ready = (q.size() < DEPTH);
        check("in_ready", 32'(in_ready), 32'(ready));
        if (q.size() > 0) begin
            check("alu_a", 32'(alu_a), 32'(q[0].a));
            check("alu_b", 32'(alu_b), 32'(q[0].b));
            check("alu_op", 32'(alu_op), 32'(q[0].op));
        end else begin
            check("alu_a_empty", 32'(alu_a), BYP ? 32'(a) : 32'd0);
            check("alu_op_empty", 32'(alu_op), BYP ? 32'(op) : 32'd0);
        end
        c     = '{a: a, b: b, op: op};
        push  = iv && ready;
        sfree = !m_valid || ordy;
        if (fl) begin
            model_clear(1'b0);
        end else begin
            if (sfree && q.size() > 0) begin
                load_slot(q.pop_front());
                if (push) q.push_back(c);
            end else if (BYP && sfree && push) begin
                load_slot(c);
            end else begin
                if (ordy) m_valid = 1'b0;
                if (push) q.push_back(c);
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_result", 32'(out_result), 32'(m_res));
        check("out_zero", 32'(out_zero), 32'(m_z));
        check("out_carry", 32'(out_carry), 32'(m_c));
        check("out_op", 32'(out_op), 32'(m_op));
        check("count", 32'(count), 32'(q.size()));
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 8'h00, 8'h00, 3'd0, ordy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_result"}, 32'(out_result), 32'd0);
        check({tag, "_out_flags"}, 32'({out_zero, out_carry}), 32'd0);
        check({tag, "_out_op"}, 32'(out_op), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        check_reset_state("rst_pulse");
        model_clear(1'b1);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        model_clear(1'b1);
        #2;
        check_reset_state("reset");
        #10 rst_n = 1'b1;

        // Single ADD 0x80 + 0x80
        cycle(1'b1, 8'h80, 8'h80, 3'd0, 1'b1, 1'b0);
        idle(1'b1);
        check("add_result", 32'(out_result), 32'h00);
        check("add_flags", 32'({out_zero, out_carry}), 32'b11);
        idle(1'b1);

        // Back-pressure: six offers with the consumer stalled
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 8'(8'h10 + i), 8'h01, 3'd0, 1'b0, 1'b0);
        check("bp_count_full", 32'(count), 32'(DEPTH));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 7; i++) idle(1'b1);

        // Streaming SUB / SLL / SRL
        cycle(1'b1, 8'h05, 8'h06, 3'd1, 1'b1, 1'b0);
        cycle(1'b1, 8'h81, 8'h00, 3'd6, 1'b1, 1'b0);
        cycle(1'b1, 8'h01, 8'h00, 3'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Wrap-around with occasional stalls
        for (int i = 0; i < 3 * DEPTH; i++)
            cycle(1'b1, 8'(i * 7), 8'(i), 3'(i), ($urandom_range(0, 3) != 0), 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        // Full with a simultaneous pop: nothing pushed that cycle
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b1, 8'(8'h30 + i), 8'h02, 3'd4, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'(DEPTH));
        cycle(1'b1, 8'hEE, 8'hEE, 3'd3, 1'b1, 1'b0);
        check("full_pop_count", 32'(count), 32'(DEPTH - 1));

        // Flush with count=3, slot occupied and a command offered
        check("pre_flush_valid", 32'(out_valid), 32'd1);
        cycle(1'b1, 8'h55, 8'h66, 3'd2, 1'b0, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        idle(1'b1);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b0);
        reset_pulse();
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0)
                reset_pulse();
            else
                cycle(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 3'($urandom),
                      ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
